// File: rtl/regfile_mp.sv
// regfile_mp: multi-port architectural register file with a busy scoreboard.
// NRD combinational read ports, two synchronous write ports (port 1 wins on
// address collision), and a per-register busy bit that is set by decode
// reservations and cleared by writeback. Register 0 is hardwired zero.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// to the read ports.
module regfile_mp #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NRD   = 3,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 we0,
  input  logic [AW-1:0]        wa0,
  input  logic [WIDTH-1:0]     wd0,
  input  logic                 we1,
  input  logic [AW-1:0]        wa1,
  input  logic [WIDTH-1:0]     wd1,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_addr,
  output logic                 busy_any
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [AW-1:0]    ra [NRD];

  // Register and scoreboard update; reset and register 0 force zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: every register is cleared on reset because software is allowed
      // to read any register right after reset and must see zero; this costs
      // a reset path per storage bit, so the array cannot map onto a RAM macro.
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
      end
      busy <= '0;
    end else begin
      regs[0] <= '0;
      busy[0] <= 1'b0;
      for (int r = 1; r < DEPTH; r++) begin
        // NOTE: non-blocking assignments here so every register sees the
        // pre-edge inputs, independent of loop order or other blocks.
        if (we1 && wa1 == AW'(r)) begin
          regs[r] <= wd1;
        end else if (we0 && wa0 == AW'(r)) begin
          regs[r] <= wd0;
        end
        // A new reservation outranks the writeback of the previous producer.
        if (rsv_en && rsv_addr == AW'(r)) begin
          busy[r] <= 1'b1;
        end else if ((we0 && wa0 == AW'(r)) || (we1 && wa1 == AW'(r))) begin
          busy[r] <= 1'b0;
        end
      end
    end
  end

  // Unpack the read addresses into one entry per port.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      ra[i] = rd_addr[i*AW +: AW];
    end
  end

  // Combinational read ports; address 0 always reads zero and not busy.
  always_comb begin
    // NOTE: defaults first so every path assigns every bit and no latch forms.
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (ra[i] != '0) begin
        rd_data[i*WIDTH +: WIDTH] = regs[ra[i]];
`ifdef REGFILE_BYPASS_EN
        // Forward same-cycle writes; port 1 checked last so it wins.
        if (we0 && wa0 == ra[i]) begin
          rd_data[i*WIDTH +: WIDTH] = wd0;
        end
        if (we1 && wa1 == ra[i]) begin
          rd_data[i*WIDTH +: WIDTH] = wd1;
        end
`endif
        rd_busy[i] = busy[ra[i]];
      end
    end
  end

  assign busy_any = |busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_regfile_mp;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int NRD   = 3;
  localparam int AW    = 5;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*WIDTH-1:0] rd_data;
  logic [NRD-1:0]       rd_busy;
  logic                 we0;
  logic [AW-1:0]        wa0;
  logic [WIDTH-1:0]     wd0;
  logic                 we1;
  logic [AW-1:0]        wa1;
  logic [WIDTH-1:0]     wd1;
  logic                 rsv_en;
  logic [AW-1:0]        rsv_addr;
  logic                 busy_any;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: plain arrays updated once per clock edge.
  logic [WIDTH-1:0] m_reg  [DEPTH];
  logic             m_busy [DEPTH];

  regfile_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NRD(NRD)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1),
    .wa1(wa1), .wd1(wd1), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_any(busy_any)
  );

  always #5 clk = ~clk;

  // Apply the architectural rules for one rising edge to the model.
  function automatic void model_edge();
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        m_reg[r]  = '0;
        m_busy[r] = 1'b0;
      end
    end else begin
      if (we0 && wa0 != 0) m_reg[wa0] = wd0;
      if (we1 && wa1 != 0) m_reg[wa1] = wd1;
      if (we0) m_busy[wa0] = 1'b0;
      if (we1) m_busy[wa1] = 1'b0;
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    end
  endfunction

  // What a read port should return for address a in the current cycle.
  function automatic logic [WIDTH-1:0] model_read(logic [AW-1:0] a);
    logic [WIDTH-1:0] v;
    if (a == 0) return '0;
    v = m_reg[a];
`ifdef REGFILE_BYPASS_EN
    if (we1 && wa1 == a) v = wd1;
    else if (we0 && wa0 == a) v = wd0;
`endif
    return v;
  endfunction

  function automatic logic model_busy_any();
    logic b = 1'b0;
    for (int r = 0; r < DEPTH; r++) b = b | m_busy[r];
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    rsv_en = 1'b0; rsv_addr = '0;
  endtask

  task automatic set_rd(int p, logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    rd_addr = '0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      for (int p = 0; p < NRD; p++) set_rd(p, AW'(a));
      #1;
      n_checks++;
      if (rd_data !== '0 || rd_busy !== '0 || busy_any !== 1'b0)
        $display("FAIL reset_read addr=%0d: data=%h busy=%b any=%b want 0/0/0",
                 a, rd_data, rd_busy, busy_any);
      else n_pass++;
    end
  endtask

  task automatic test_write();
    we0 = 1'b1; wa0 = 5; wd0 = 32'hDEADBEEF;
    tick();
    idle();
    set_rd(0, 5);
    #1;
    n_checks++;
    if (rd_data[0 +: WIDTH] !== 32'hDEADBEEF)
      $display("FAIL write_reg5: got %h want DEADBEEF", rd_data[0 +: WIDTH]);
    else n_pass++;

    we0 = 1'b1; wa0 = 0; wd0 = 32'h12345678;
    tick();
    idle();
    set_rd(0, 0);
    #1;
    n_checks++;
    if (rd_data[0 +: WIDTH] !== '0)
      $display("FAIL write_reg0: got %h want 00000000", rd_data[0 +: WIDTH]);
    else n_pass++;
  endtask

  task automatic test_priority();
    we0 = 1'b1; wa0 = 7; wd0 = 32'h11111111;
    we1 = 1'b1; wa1 = 7; wd1 = 32'h22222222;
    tick();
    we0 = 1'b1; wa0 = 8; wd0 = 32'h11111111;
    we1 = 1'b1; wa1 = 9; wd1 = 32'h22222222;
    tick();
    idle();
    set_rd(0, 7); set_rd(1, 8); set_rd(2, 9);
    #1;
    n_checks++;
    if (rd_data[0 +: WIDTH] !== 32'h22222222)
      $display("FAIL prio_same_addr: got %h want 22222222", rd_data[0 +: WIDTH]);
    else n_pass++;
    n_checks++;
    if (rd_data[WIDTH +: WIDTH] !== 32'h11111111 || rd_data[2*WIDTH +: WIDTH] !== 32'h22222222)
      $display("FAIL prio_diff_addr: got %h/%h want 11111111/22222222",
               rd_data[WIDTH +: WIDTH], rd_data[2*WIDTH +: WIDTH]);
    else n_pass++;
  endtask

  task automatic test_scoreboard();
    rsv_en = 1'b1; rsv_addr = 3;
    tick();
    idle();
    set_rd(1, 3);
    #1;
    n_checks++;
    if (rd_busy[1] !== 1'b1 || busy_any !== 1'b1)
      $display("FAIL rsv_set: busy=%b any=%b want 1/1", rd_busy[1], busy_any);
    else n_pass++;

    we0 = 1'b1; wa0 = 3; wd0 = 32'hA5A5A5A5;
    rsv_en = 1'b1; rsv_addr = 3;
    tick();
    idle();
    #1;
    n_checks++;
    if (rd_busy[1] !== 1'b1 || busy_any !== 1'b1)
      $display("FAIL rsv_beats_clear: busy=%b any=%b want 1/1", rd_busy[1], busy_any);
    else n_pass++;

    we1 = 1'b1; wa1 = 3; wd1 = 32'h5A5A5A5A;
    tick();
    idle();
    #1;
    n_checks++;
    if (rd_busy[1] !== 1'b0 || busy_any !== 1'b0 || rd_data[WIDTH +: WIDTH] !== 32'h5A5A5A5A)
      $display("FAIL write_clear: busy=%b any=%b data=%h want 0/0/5a5a5a5a",
               rd_busy[1], busy_any, rd_data[WIDTH +: WIDTH]);
    else n_pass++;

    rsv_en = 1'b1; rsv_addr = 0;
    tick();
    idle();
    set_rd(1, 0);
    #1;
    n_checks++;
    if (rd_busy[1] !== 1'b0 || busy_any !== 1'b0)
      $display("FAIL rsv_reg0: busy=%b any=%b want 0/0", rd_busy[1], busy_any);
    else n_pass++;
  endtask

  task automatic test_bypass();
    logic [WIDTH-1:0] before_exp;
    set_rd(2, 10);
    we1 = 1'b1; wa1 = 10; wd1 = 32'hCAFEF00D;
    #1;
`ifdef REGFILE_BYPASS_EN
    before_exp = 32'hCAFEF00D;
`else
    before_exp = m_reg[10];
`endif
    n_checks++;
    if (rd_data[2*WIDTH +: WIDTH] !== before_exp)
      $display("FAIL bypass_before_edge: got %h want %h", rd_data[2*WIDTH +: WIDTH], before_exp);
    else n_pass++;
    tick();
    idle();
    #1;
    n_checks++;
    if (rd_data[2*WIDTH +: WIDTH] !== 32'hCAFEF00D)
      $display("FAIL bypass_after_edge: got %h want CAFEF00D", rd_data[2*WIDTH +: WIDTH]);
    else n_pass++;
  endtask

  task automatic drive_random();
    we0 = 1'($urandom_range(1, 0));
    wa0 = AW'($urandom);
    wd0 = $urandom;
    we1 = 1'($urandom_range(1, 0));
    wa1 = ($urandom_range(3, 0) == 0) ? wa0 : AW'($urandom);
    wd1 = $urandom;
    rsv_en = ($urandom_range(2, 0) == 0);
    rsv_addr = ($urandom_range(3, 0) == 0) ? wa1 : AW'($urandom);
    for (int p = 0; p < NRD; p++) begin
      case ($urandom_range(3, 0))
        0: set_rd(p, wa0);
        1: set_rd(p, wa1);
        default: set_rd(p, AW'($urandom));
      endcase
    end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int c = 0; c < 200; c++) begin
      drive_random();
      #1;
      for (int p = 0; p < NRD; p++) begin
        logic [AW-1:0] a;
        a = rd_addr[p*AW +: AW];
        n_checks++;
        if (rd_data[p*WIDTH +: WIDTH] !== model_read(a) || rd_busy[p] !== m_busy[a])
          $display("FAIL random_read cyc=%0d port=%0d addr=%0d: data=%h busy=%b want %h/%b",
                   c, p, a, rd_data[p*WIDTH +: WIDTH], rd_busy[p], model_read(a), m_busy[a]);
        else n_pass++;
      end
      n_checks++;
      if (busy_any !== model_busy_any())
        $display("FAIL random_busy_any cyc=%0d: got %b want %b", c, busy_any, model_busy_any());
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_mid_reset();
    drive_random();
    we0 = 1'b1; we1 = 1'b1; rsv_en = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
    for (int a = 0; a < DEPTH; a++) begin
      for (int p = 0; p < NRD; p++) set_rd(p, AW'(a));
      #1;
      n_checks++;
      if (rd_data !== '0 || rd_busy !== '0 || busy_any !== 1'b0)
        $display("FAIL mid_reset addr=%0d: data=%h busy=%b any=%b want 0/0/0",
                 a, rd_data, rd_busy, busy_any);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_priority();
    test_scoreboard();
    test_bypass();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
